hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. Sequences the PC, IF/ID, ID/EX and EX/MEM pipeline registers: inserts load-use bubbles into ID/EX, flushes IF/ID and ID/EX on taken branches, and freezes the pipe while a multi-cycle data-memory access is outstanding. It also keeps saturating stall and flush counters and a sticky memory-timeout flag for debug.

## Interface
- LOAD_STALL, 1: bubble cycles per load-use hazard; legal range 1-3.
- MEM_TIMEOUT, 64: MEM_WAIT cycles before the error flag is set.
- CNT_W, 16: width of the performance counters.
- clk  in  1  core clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-high reset. Despite the name, 1 means reset.
- idex_memread  in  1  the instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ifid_rs1, ifid_rs2  in  5 each  source registers of the instruction in ID.
- use_rs1, use_rs2  in  1 each  the ID instruction actually reads rs1 or rs2.
- branch_taken  in  1  EX has resolved a taken branch or jump.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables.
- ifid_flush, idex_flush  out  1 each  zero the register's control fields on the next edge (insert a bubble).
- state_o  out  2  current FSM state.
- stall_cnt  out  CNT_W  count of cycles with pc_write=0; saturates.
- flush_cnt  out  CNT_W  count of branch flush events; saturates.
- mem_err  out  1  sticky; set when MEM_TIMEOUT is reached.

## Operation
- Hazard terms, combinational:
  - lu = idex_memread & idex_rd!=0 & ((use_rs1 & idex_rd==ifid_rs1) | (use_rs2 & idex_rd==ifid_rs2)).
  - mw = mem_req & !mem_ready.
- Default outputs: all write enables 1, both flushes 0.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2. Encoding 3 is illegal and is treated as RUN.
- RUN. Priorities are mw > branch_taken > lu.
  - mw: all four write enables 0, no flush. Next state MEM_WAIT, wait counter := 1.
  - branch_taken: ifid_flush=1, idex_flush=1, pc_write=1. flush_cnt +1. Any lu in the same cycle is discarded.
  - lu: pc_write=0, ifid_write=0, idex_flush=1. If LOAD_STALL>1, next state LU_STALL with bubble counter := LOAD_STALL-1; otherwise stay in RUN.
- LU_STALL:
  - Each cycle applies the same outputs as lu and decrements the counter.
  - When the counter reaches 1, the next state is RUN.
  - If mw occurs, go to MEM_WAIT; the stall is abandoned.
  - If branch_taken occurs, apply the RUN branch behaviour and go to RUN.
- MEM_WAIT:
  - While !mem_ready: all write enables 0, wait counter +1.
  - When mem_ready=1: enables are released in that same cycle and the next state is RUN.
  - When the wait counter reaches MEM_TIMEOUT: set mem_err and force RUN. The pipe proceeds with whatever data is present.
- Counters:
  - stall_cnt +1 on every non-reset cycle with pc_write=0.
  - Both counters hold at all-ones.
  - mem_err is cleared only by reset.

## Timing
- Hazard decisions are combinational, in the same cycle the inputs are valid. Flush and write effects land on the next rising edge.
- Load-use penalty is exactly LOAD_STALL bubbles. Branch penalty is 2 flushed slots. Memory stall lasts until the cycle mem_ready is asserted, inclusive.
- Reset (async assert, sampled deassert):
  - state_o=RUN, counters=0, mem_err=0.
  - While rst_n=1, all write enables are 0 and both flushes are 0.
- Reset asserted mid-LU_STALL or mid-MEM_WAIT aborts the operation immediately. The first post-reset cycle is RUN.
- mem_ready arriving in the same cycle as mem_req: no stall and no state change.
- idex_rd=0 never causes a stall.

## Structure
- Shared package hazard_ctrl_pkg holds the state enum with its encodings (RUN, LU_STALL, MEM_WAIT) and the default parameter constants.
- One sub-module, sat_counter (width parameter, inc, clear, saturating): instantiated twice, for stall_cnt and flush_cnt.
- The wait and bubble counters stay inline in the FSM.

## Test plan
- Reset check: while rst_n=1, all enables are 0. After release, state_o=0, stall_cnt=0, mem_err=0.
- Load-use, LOAD_STALL=2:
  - Stimulus: idex_memread=1, idex_rd=5, ifid_rs2=5, use_rs2=1.
  - Required: pc_write=0 and idex_flush=1 for exactly 2 cycles, then RUN, stall_cnt=2.
  - Repeat with idex_rd=0 or use_rs2=0: no stall.
- Taken branch in the same cycle as lu: ifid_flush=idex_flush=1 and pc_write=1 for one cycle, flush_cnt=1, no stall.
- Memory wait:
  - Stimulus: mem_req=1 with mem_ready low for 4 cycles, then high.
  - Required: exmem_write=0 for 4 cycles, released in the mem_ready cycle, stall_cnt=4.
  - Also: mem_req with mem_ready=1 in the same cycle causes no stall.
- Timeout, MEM_TIMEOUT=8: mem_ready held low gives mem_err=1 after 8 MEM_WAIT cycles, then RUN. mem_err stays 1 until reset.
- Saturation and abort:
  - Preload stall_cnt near all-ones by forcing stalls: it holds at 0xFFFF.
  - Assert reset during MEM_WAIT: immediate state_o=0 and counters=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline hazard/stall controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam int DEF_LOAD_STALL  = 1;
  localparam int DEF_MEM_TIMEOUT = 64;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and the pipeline-register controls driven back.
interface hazard_ctrl_if #(
  parameter int CNT_W = hazard_ctrl_pkg::DEF_CNT_W
);
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             use_rs1;
  logic             use_rs2;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_err;

  modport master (
    output idex_memread, idex_rd, ifid_rs1, ifid_rs2, use_rs1, use_rs2,
           branch_taken, mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_flush, state_o, stall_cnt, flush_cnt, mem_err
  );

  modport slave (
    input  idex_memread, idex_rd, ifid_rs1, ifid_rs2, use_rs1, use_rs2,
           branch_taken, mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_flush, state_o, stall_cnt, flush_cnt, mem_err
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, memory-wait freeze,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL  = DEF_LOAD_STALL,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);
  localparam logic [1:0] ST_RUN      = 2'(RUN);
  localparam logic [1:0] ST_LU_STALL = 2'(LU_STALL);
  localparam logic [1:0] ST_MEM_WAIT = 2'(MEM_WAIT);
  localparam int         WW          = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);
  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_STALL - 1);

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic          err_q, err_d;
  logic          lu, mw;
  logic          pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f;
  logic          flush_inc, stall_inc;

  assign lu = hz.idex_memread && (hz.idex_rd != 5'd0) &&
              ((hz.use_rs1 && (hz.idex_rd == hz.ifid_rs1)) ||
               (hz.use_rs2 && (hz.idex_rd == hz.ifid_rs2)));
  assign mw = hz.mem_req && !hz.mem_ready;

  always_comb begin
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    idex_w    = 1'b1;
    exmem_w   = 1'b1;
    ifid_f    = 1'b0;
    idex_f    = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    err_d     = err_q;
    case (state_q)
      ST_LU_STALL: begin
        if (mw) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          state_d = ST_MEM_WAIT;
          wcnt_d  = WW'(1);
        end else if (hz.branch_taken) begin
          ifid_f    = 1'b1;
          idex_f    = 1'b1;
          flush_inc = 1'b1;
          state_d   = ST_RUN;
        end else begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
          if (bcnt_q <= 2'd1)
            state_d = ST_RUN;
          else
            bcnt_d = bcnt_q - 2'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (hz.mem_ready) begin
          state_d = ST_RUN;
        end else begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          // Give up on a hung memory: flag it and let the pipe run on.
          if (wcnt_q >= WAIT_MAX) begin
            err_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            wcnt_d = wcnt_q + WW'(1);
          end
        end
      end
      default: begin
        if (mw) begin
          {pc_w, ifid_w, idex_w, exmem_w} = 4'b0000;
          state_d = ST_MEM_WAIT;
          wcnt_d  = WW'(1);
        end else if (hz.branch_taken) begin
          ifid_f    = 1'b1;
          idex_f    = 1'b1;
          flush_inc = 1'b1;
          state_d   = ST_RUN;
        end else if (lu) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
          state_d = ST_RUN;
          if (LOAD_STALL > 1) begin
            state_d = ST_LU_STALL;
            bcnt_d  = BUBBLE_INIT;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  // Reset holds the whole pipe frozen with no bubbles injected.
  assign hz.pc_write    = pc_w    & ~rst_n;
  assign hz.ifid_write  = ifid_w  & ~rst_n;
  assign hz.idex_write  = idex_w  & ~rst_n;
  assign hz.exmem_write = exmem_w & ~rst_n;
  assign hz.ifid_flush  = ifid_f  & ~rst_n;
  assign hz.idex_flush  = idex_f  & ~rst_n;
  assign hz.state_o     = state_q;
  assign hz.mem_err     = err_q;

  assign stall_inc = ~pc_w & ~rst_n;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst_n),
    .inc_i   (stall_inc),
    .clear_i (1'b0),
    .cnt_o   (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst_n),
    .inc_i   (flush_inc),
    .clear_i (1'b0),
    .cnt_o   (hz.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with LOAD_STALL=2, MEM_TIMEOUT=8, CNT_W=16.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_ctrl_if #(.CNT_W(16)) hz ();

  hazard_ctrl #(
    .LOAD_STALL  (2),
    .MEM_TIMEOUT (8),
    .CNT_W       (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.idex_memread = 1'b0;
    hz.idex_rd      = 5'd0;
    hz.ifid_rs1     = 5'd0;
    hz.ifid_rs2     = 5'd0;
    hz.use_rs1      = 1'b0;
    hz.use_rs2      = 1'b0;
    hz.branch_taken = 1'b0;
    hz.mem_req      = 1'b0;
    hz.mem_ready    = 1'b0;
  endtask

  task automatic set_lu();
    hz.idex_memread = 1'b1;
    hz.idex_rd      = 5'd5;
    hz.ifid_rs2     = 5'd5;
    hz.use_rs2      = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    clear_in();
    next();
    next();
    #2;
    chk("rst_enables", {28'd0, hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}, 32'h0);
    chk("rst_flushes", {30'd0, hz.ifid_flush, hz.idex_flush}, 32'h0);

    next();
    rst_n = 1'b0;
    #2;
    chk("post_rst_state", {30'd0, hz.state_o}, 32'd0);
    chk("post_rst_stall_cnt", {16'd0, hz.stall_cnt}, 32'd0);
    chk("post_rst_flush_cnt", {16'd0, hz.flush_cnt}, 32'd0);
    chk("post_rst_mem_err", {31'd0, hz.mem_err}, 32'd0);
    chk("post_rst_enables", {28'd0, hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}, 32'hF);

    // Load-use: two bubble cycles, second one driven by LU_STALL alone.
    next();
    set_lu();
    #2;
    chk("lu1_pc_write", {31'd0, hz.pc_write}, 32'd0);
    chk("lu1_ifid_write", {31'd0, hz.ifid_write}, 32'd0);
    chk("lu1_idex_flush", {31'd0, hz.idex_flush}, 32'd1);
    next();
    clear_in();
    #2;
    chk("lu2_state", {30'd0, hz.state_o}, 32'd1);
    chk("lu2_pc_write", {31'd0, hz.pc_write}, 32'd0);
    chk("lu2_idex_flush", {31'd0, hz.idex_flush}, 32'd1);
    next();
    #2;
    chk("lu3_state", {30'd0, hz.state_o}, 32'd0);
    chk("lu3_pc_write", {31'd0, hz.pc_write}, 32'd1);
    chk("lu3_idex_flush", {31'd0, hz.idex_flush}, 32'd0);
    chk("lu3_stall_cnt", {16'd0, hz.stall_cnt}, 32'd2);

    // rd=0 never stalls; use_rs2=0 never stalls.
    hz.idex_memread = 1'b1;
    hz.idex_rd      = 5'd0;
    hz.ifid_rs2     = 5'd0;
    hz.use_rs2      = 1'b1;
    #1;
    chk("rd0_pc_write", {31'd0, hz.pc_write}, 32'd1);
    chk("rd0_idex_flush", {31'd0, hz.idex_flush}, 32'd0);
    next();
    set_lu();
    hz.use_rs2 = 1'b0;
    #2;
    chk("nouse_pc_write", {31'd0, hz.pc_write}, 32'd1);
    next();
    clear_in();
    #2;
    chk("nostall_state", {30'd0, hz.state_o}, 32'd0);
    chk("nostall_stall_cnt", {16'd0, hz.stall_cnt}, 32'd2);

    // Branch beats load-use in the same cycle.
    set_lu();
    hz.branch_taken = 1'b1;
    #2;
    chk("br_ifid_flush", {31'd0, hz.ifid_flush}, 32'd1);
    chk("br_idex_flush", {31'd0, hz.idex_flush}, 32'd1);
    chk("br_pc_write", {31'd0, hz.pc_write}, 32'd1);
    next();
    clear_in();
    #2;
    chk("br_flush_cnt", {16'd0, hz.flush_cnt}, 32'd1);
    chk("br_state", {30'd0, hz.state_o}, 32'd0);
    chk("br_stall_cnt", {16'd0, hz.stall_cnt}, 32'd2);
    chk("br_after_flush", {31'd0, hz.ifid_flush}, 32'd0);

    // Memory wait: 4 frozen cycles, release in the mem_ready cycle.
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b0;
    #2;
    chk("mw1_exmem_write", {31'd0, hz.exmem_write}, 32'd0);
    chk("mw1_state", {30'd0, hz.state_o}, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      next();
      #2;
      chk("mw_exmem_write", {31'd0, hz.exmem_write}, 32'd0);
      chk("mw_state", {30'd0, hz.state_o}, 32'd2);
    end
    next();
    hz.mem_ready = 1'b1;
    #2;
    chk("mw_rel_exmem_write", {31'd0, hz.exmem_write}, 32'd1);
    chk("mw_rel_pc_write", {31'd0, hz.pc_write}, 32'd1);
    next();
    clear_in();
    #2;
    chk("mw_done_state", {30'd0, hz.state_o}, 32'd0);
    chk("mw_done_stall_cnt", {16'd0, hz.stall_cnt}, 32'd6);

    // Access that completes immediately: no stall.
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b1;
    #2;
    chk("fast_exmem_write", {31'd0, hz.exmem_write}, 32'd1);
    next();
    clear_in();
    #2;
    chk("fast_state", {30'd0, hz.state_o}, 32'd0);
    chk("fast_stall_cnt", {16'd0, hz.stall_cnt}, 32'd6);

    // Timeout after 8 MEM_WAIT cycles.
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b0;
    #2;
    chk("to_entry_exmem", {31'd0, hz.exmem_write}, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      next();
      #2;
      chk("to_wait_state", {30'd0, hz.state_o}, 32'd2);
      chk("to_wait_err", {31'd0, hz.mem_err}, 32'd0);
    end
    next();
    clear_in();
    #2;
    chk("to_mem_err", {31'd0, hz.mem_err}, 32'd1);
    chk("to_state", {30'd0, hz.state_o}, 32'd0);
    chk("to_pc_write", {31'd0, hz.pc_write}, 32'd1);
    chk("to_stall_cnt", {16'd0, hz.stall_cnt}, 32'd15);
    next();
    next();
    #2;
    chk("to_err_sticky", {31'd0, hz.mem_err}, 32'd1);

    // Continuous load-use well past 2^16 stalls: counter must hold.
    set_lu();
    repeat (65540) @(posedge clk);
    #1;
    clear_in();
    #2;
    chk("sat_stall_cnt", {16'd0, hz.stall_cnt}, 32'hFFFF);
    next();
    next();
    #2;
    chk("sat_hold", {16'd0, hz.stall_cnt}, 32'hFFFF);
    chk("sat_flush_cnt", {16'd0, hz.flush_cnt}, 32'd1);

    // Reset mid MEM_WAIT aborts at once.
    hz.mem_req   = 1'b1;
    hz.mem_ready = 1'b0;
    next();
    #2;
    chk("abort_pre_state", {30'd0, hz.state_o}, 32'd2);
    rst_n = 1'b1;
    #1;
    chk("abort_state", {30'd0, hz.state_o}, 32'd0);
    chk("abort_stall_cnt", {16'd0, hz.stall_cnt}, 32'd0);
    chk("abort_flush_cnt", {16'd0, hz.flush_cnt}, 32'd0);
    chk("abort_mem_err", {31'd0, hz.mem_err}, 32'd0);
    chk("abort_enables", {28'd0, hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}, 32'h0);
    next();
    clear_in();
    rst_n = 1'b0;
    #2;
    chk("rel_state", {30'd0, hz.state_o}, 32'd0);
    chk("rel_enables", {28'd0, hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
